// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry registered response slot per requester.
module alu_arbiter #(
  parameter int DW   = 32,
  parameter int OPW  = 5,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic [OPW-1:0]  req0_op,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic [OPW-1:0]  req1_op,
  input  logic [TAGW-1:0] req1_tag,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [DW-1:0]   rsp0_c,
  output logic            rsp0_zero,
  output logic [TAGW-1:0] rsp0_tag,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [DW-1:0]   rsp1_c,
  output logic            rsp1_zero,
  output logic [TAGW-1:0] rsp1_tag,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [DW-1:0]   alu_c,
  input  logic            alu_zero
);

  // Handshakes: a request transfers on an edge where reqN_valid & reqN_ready;
  // a response transfers on an edge where rspN_valid & rspN_ready. Valid never
  // waits on ready, and ready is only raised for a valid request.

  logic last_gnt;
  logic elig0, elig1;
  logic gnt0, gnt1;

  // A requester may issue when its slot is empty or is being drained this cycle.
  assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

  assign gnt0 = elig0 & (~elig1 | last_gnt);
  assign gnt1 = elig1 & (~elig0 | ~last_gnt);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (gnt0) begin
      alu_a  = req0_a;
      alu_b  = req0_b;
      alu_op = req0_op;
    end else if (gnt1) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = req1_op;
    end
  end

  // Reset value 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_gnt <= 1'b1;
    end else if (gnt0) begin
      last_gnt <= 1'b0;
    end else if (gnt1) begin
      last_gnt <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp0_valid <= 1'b0;
      rsp0_c     <= '0;
      rsp0_zero  <= 1'b0;
      rsp0_tag   <= '0;
    end else if (gnt0) begin
      rsp0_valid <= 1'b1;
      rsp0_c     <= alu_c;
      rsp0_zero  <= alu_zero;
      rsp0_tag   <= req0_tag;
    end else if (rsp0_ready) begin
      rsp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp1_valid <= 1'b0;
      rsp1_c     <= '0;
      rsp1_zero  <= 1'b0;
      rsp1_tag   <= '0;
    end else if (gnt1) begin
      rsp1_valid <= 1'b1;
      rsp1_c     <= alu_c;
      rsp1_zero  <= alu_zero;
      rsp1_tag   <= req1_tag;
    end else if (rsp1_ready) begin
      rsp1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// checked against a behavioural arbitration model and per-requester result queues.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OPW = 5;
  localparam int TAGW = 4;
  localparam int EW = TAGW + 1 + DW;

  localparam logic [OPW-1:0] OP_ADD = 5'd3;
  localparam logic [OPW-1:0] OP_SUB = 5'd4;
  localparam logic [OPW-1:0] OP_AND = 5'd5;
  localparam logic [OPW-1:0] OP_OR  = 5'd6;
  localparam logic [OPW-1:0] OP_XOR = 5'd8;
  localparam logic [OPW-1:0] OP_SLT = 5'd9;

  logic clk;
  logic rstn;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0] req0_op, req1_op;
  logic [TAGW-1:0] req0_tag, req1_tag;
  logic rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [DW-1:0] rsp0_c, rsp1_c;
  logic [TAGW-1:0] rsp0_tag, rsp1_tag;
  logic [DW-1:0] alu_a, alu_b, alu_c;
  logic [OPW-1:0] alu_op;
  logic alu_zero;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DW(DW), .OPW(OPW), .TAGW(TAGW)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c),
    .rsp0_zero(rsp0_zero), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c),
    .rsp1_zero(rsp1_zero), .rsp1_tag(rsp1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .alu_zero(alu_zero)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared ALU model ----------------
  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OPW-1:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  assign alu_c    = alu_fn(alu_a, alu_b, alu_op);
  assign alu_zero = (alu_c == '0);

  // ---------------- reference model ----------------
  // Served-last requester and slot occupancy; results are queued per requester
  // in issue order and popped when the requester takes a response.
  logic       m_last;
  logic [1:0] m_valid;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

  function automatic logic [1:0] pred_gnt();
    logic can0, can1;
    can0 = req0_valid && (!m_valid[0] || rsp0_ready);
    can1 = req1_valid && (!m_valid[1] || rsp1_ready);
    if (can0 && can1) return (m_last == 1'b1) ? 2'b01 : 2'b10;
    return {can1, can0};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_last  <= 1'b1;
      m_valid <= 2'b00;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (pred_gnt() == 2'b01) begin
        exp_q0.push_back({req0_tag, alu_fn(req0_a, req0_b, req0_op) == '0,
                          alu_fn(req0_a, req0_b, req0_op)});
        m_last <= 1'b0;
      end else if (pred_gnt() == 2'b10) begin
        exp_q1.push_back({req1_tag, alu_fn(req1_a, req1_b, req1_op) == '0,
                          alu_fn(req1_a, req1_b, req1_op)});
        m_last <= 1'b1;
      end
      m_valid[0] <= pred_gnt()[0] || (m_valid[0] && !rsp0_ready);
      m_valid[1] <= pred_gnt()[1] || (m_valid[1] && !rsp1_ready);
    end
  end

  // Scoreboard: every drained response must match the oldest expected result.
  always @(negedge clk) begin
    if (rstn && rsp0_valid && rsp0_ready) begin
      checks++;
      if (exp_q0.size() == 0) begin
        errors++;
        $display("FAIL sb_rsp0: got %h with no expected result", {rsp0_tag, rsp0_zero, rsp0_c});
      end else if ({rsp0_tag, rsp0_zero, rsp0_c} !== exp_q0[0]) begin
        errors++;
        $display("FAIL sb_rsp0: got %h expected %h", {rsp0_tag, rsp0_zero, rsp0_c}, exp_q0[0]);
        void'(exp_q0.pop_front());
      end else begin
        void'(exp_q0.pop_front());
      end
    end
    if (rstn && rsp1_valid && rsp1_ready) begin
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("FAIL sb_rsp1: got %h with no expected result", {rsp1_tag, rsp1_zero, rsp1_c});
      end else if ({rsp1_tag, rsp1_zero, rsp1_c} !== exp_q1[0]) begin
        errors++;
        $display("FAIL sb_rsp1: got %h expected %h", {rsp1_tag, rsp1_zero, rsp1_c}, exp_q1[0]);
        void'(exp_q1.pop_front());
      end else begin
        void'(exp_q1.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req0(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [OPW-1:0] op, input logic [TAGW-1:0] tag);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_tag = tag;
  endtask

  task automatic set_req1(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [OPW-1:0] op, input logic [TAGW-1:0] tag);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_tag = tag;
  endtask

  task automatic idle_reqs();
    set_req0(1'b0, '0, '0, '0, '0);
    set_req1(1'b0, '0, '0, '0, '0);
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic apply_reset();
    idle_reqs();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_reqs();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    rstn = 1'b0;
    #3;
    checks++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_valid: got %b expected 00", {rsp0_valid, rsp1_valid});
    end
    checks++;
    if ({rsp0_c, rsp0_zero, rsp0_tag, rsp1_c, rsp1_zero, rsp1_tag} !== '0) begin
      errors++; $display("FAIL reset_data: got %h/%h expected 0", {rsp0_c, rsp0_zero, rsp0_tag},
                         {rsp1_c, rsp1_zero, rsp1_tag});
    end
    checks++;
    if ({req0_ready, req1_ready, alu_a, alu_b, alu_op} !== '0) begin
      errors++; $display("FAIL reset_idle_outputs: ready=%b alu_op=%0d expected 0",
                         {req0_ready, req1_ready}, alu_op);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_single();
    rsp0_ready = 1'b0;
    set_req0(1'b1, 32'd5, 32'd7, OP_ADD, 4'd3);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== {32'd5, 32'd7, OP_ADD}) begin
      errors++; $display("FAIL single_alu_drive: got a=%0d b=%0d op=%0d expected 5 7 %0d",
                         alu_a, alu_b, alu_op, OP_ADD);
    end
    @(posedge clk); #1;
    set_req0(1'b0, '0, '0, '0, '0);
    checks++;
    if ({rsp0_valid, rsp0_c, rsp0_zero, rsp0_tag} !== {1'b1, 32'd12, 1'b0, 4'd3}) begin
      errors++; $display("FAIL single_rsp: got v=%b c=%0d z=%b tag=%0d expected 1 12 0 3",
                         rsp0_valid, rsp0_c, rsp0_zero, rsp0_tag);
    end
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got valid=%b expected 0", rsp0_valid);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set_req0(1'b1, 32'd9, 32'd9, OP_SUB, 4'd1);
    set_req1(1'b1, 32'd1, 32'd2, OP_XOR, 4'd2);
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL contention_grant[%0d]: got r1r0=%b", i, {req1_ready, req0_ready});
      end
      @(posedge clk); #1;
      if (i == 0) begin
        checks++;
        if ({rsp0_valid, rsp0_c, rsp0_zero} !== {1'b1, 32'd0, 1'b1}) begin
          errors++; $display("FAIL contention_rsp0: got v=%b c=%0d z=%b expected 1 0 1",
                             rsp0_valid, rsp0_c, rsp0_zero);
        end
      end
      if (i == 1) begin
        checks++;
        if ({rsp1_valid, rsp1_c, rsp1_zero} !== {1'b1, 32'd3, 1'b0}) begin
          errors++; $display("FAIL contention_rsp1: got v=%b c=%0d z=%b expected 1 3 0",
                             rsp1_valid, rsp1_c, rsp1_zero);
        end
      end
    end
    idle_reqs();
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    apply_reset();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    set_req0(1'b1, 32'd20, 32'd22, OP_ADD, 4'd5);
    @(posedge clk); #1;
    set_req0(1'b1, 32'd50, 32'd10, OP_SUB, 4'd6);
    set_req1(1'b1, 32'd1, 32'd1, OP_ADD, 4'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
        errors++; $display("FAIL bp_stall[%0d]: got r0r1=%b expected 01", i, {req0_ready, req1_ready});
      end
      checks++;
      if ({rsp0_valid, rsp0_c, rsp0_zero, rsp0_tag} !== {1'b1, 32'd42, 1'b0, 4'd5}) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b c=%0d tag=%0d expected 1 42 5",
                           i, rsp0_valid, rsp0_c, rsp0_tag);
      end
      @(posedge clk); #1;
    end
    rsp0_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL bp_release_grant: got r0r1=%b expected 10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    idle_reqs();
    checks++;
    if ({rsp0_valid, rsp0_c, rsp0_tag} !== {1'b1, 32'd40, 4'd6}) begin
      errors++; $display("FAIL bp_new_result: got v=%b c=%0d tag=%0d expected 1 40 6",
                         rsp0_valid, rsp0_c, rsp0_tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    rsp1_ready = 1'b1;
    idle_reqs();
    for (int i = 0; i < 4; i++) begin
      set_req1(1'b1, DW'(i), 32'd100, OP_ADD, TAGW'(10 + i));
      #1;
      checks++;
      if (req1_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, req1_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({rsp1_valid, rsp1_tag, rsp1_c} !== {1'b1, TAGW'(10 + i), DW'(100 + i)}) begin
        errors++; $display("FAIL b2b_rsp[%0d]: got v=%b tag=%0d c=%0d expected 1 %0d %0d",
                           i, rsp1_valid, rsp1_tag, rsp1_c, 10 + i, 100 + i);
      end
    end
    idle_reqs();
    @(posedge clk); #1;
    checks++;
    if (rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got valid=%b expected 0", rsp1_valid);
    end
  endtask

  task automatic test_reset_midop();
    rsp1_ready = 1'b0;
    set_req1(1'b1, 32'd3, 32'd4, OP_OR, 4'd9);
    @(posedge clk); #1;
    idle_reqs();
    checks++;
    if ({rsp1_valid, rsp1_tag} !== {1'b1, 4'd9}) begin
      errors++; $display("FAIL midop_held: got v=%b tag=%0d expected 1 9", rsp1_valid, rsp1_tag);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp1_tag, rsp1_c} !== '0) begin
      errors++; $display("FAIL midop_async_clear: got v=%b tag=%0d c=%0d expected 0",
                         {rsp0_valid, rsp1_valid}, rsp1_tag, rsp1_c);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set_req0(1'b1, 32'd1, 32'd2, OP_AND, 4'd1);
    set_req1(1'b1, 32'd3, 32'd4, OP_ADD, 4'd2);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL midop_first_tie: got r0r1=%b expected 10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    idle_reqs();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready, alu_a, alu_b, alu_op} !== '0) begin
        errors++; $display("FAIL idle_outputs[%0d]: ready=%b a=%0d b=%0d op=%0d expected 0",
                           i, {req0_ready, req1_ready}, alu_a, alu_b, alu_op);
      end
      @(posedge clk); #1;
    end
    // Requester 0 was served last, so the next tie goes to requester 1.
    set_req0(1'b1, 32'd8, 32'd8, OP_SUB, 4'd4);
    set_req1(1'b1, 32'd8, 32'd1, OP_SLT, 4'd5);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL idle_last_gnt_kept: got r0r1=%b expected 01", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    idle_reqs();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [OPW-1:0] op_tbl[6];
    logic [1:0] g;
    op_tbl = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT};
    for (int i = 0; i < 400; i++) begin
      set_req0($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0 ? DW'($urandom_range(0, 3)) : $urandom(),
               $urandom_range(0, 3) == 0 ? DW'($urandom_range(0, 3)) : $urandom(),
               op_tbl[$urandom_range(0, 5)], TAGW'($urandom()));
      set_req1($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0 ? DW'($urandom_range(0, 3)) : $urandom(),
               $urandom_range(0, 3) == 0 ? DW'($urandom_range(0, 3)) : $urandom(),
               op_tbl[$urandom_range(0, 5)], TAGW'($urandom()));
      rsp0_ready = $urandom_range(0, 9) < 6;
      rsp1_ready = $urandom_range(0, 9) < 6;
      #1;
      g = pred_gnt();
      checks++;
      if ({req1_ready, req0_ready} !== g) begin
        errors++; $display("FAIL rand_grant[%0d]: got r1r0=%b expected %b", i, {req1_ready, req0_ready}, g);
      end
      checks++;
      if ({alu_a, alu_b, alu_op} !== (g[0] ? {req0_a, req0_b, req0_op} :
                                      g[1] ? {req1_a, req1_b, req1_op} : {DW'(0), DW'(0), OPW'(0)})) begin
        errors++; $display("FAIL rand_alu_drive[%0d]: got a=%h b=%h op=%0d grant=%b", i, alu_a, alu_b, alu_op, g);
      end
      @(posedge clk); #1;
      checks++;
      if ({rsp1_valid, rsp0_valid} !== m_valid) begin
        errors++; $display("FAIL rand_rsp_valid[%0d]: got %b expected %b", i, {rsp1_valid, rsp0_valid}, m_valid);
      end
    end
    idle_reqs();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
